// File: rtl/count_seq_pkg.sv
// Shared encodings for the count sequencer: command ops and FSM states.
package count_seq_pkg;

  typedef enum logic [1:0] {
    OP_STOP     = 2'b00,
    OP_ONESHOT  = 2'b01,
    OP_PERIODIC = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // The reserved op decodes as STOP, so only these two start a count.
  function automatic logic is_start(logic [1:0] op);
    return (op == OP_ONESHOT) || (op == OP_PERIODIC);
  endfunction

endpackage

// File: rtl/count_seq_prescaler.sv
// Enable divider: tick fires once every PRESCALE run cycles, restarted by clear.
module count_seq_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick = run && (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q;
    if (clear)    pre_d = '0;
    else if (run) pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven start/stop controller for the free-running counter.
// Optional enable prescaler is built when COUNT_SEQ_PRESCALE_EN is defined.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] period_cnt
);

  state_e           state_q, state_d;
  op_e              mode_q, mode_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] period_q, period_d;

  logic accept, start, stop, match, tick;

  // Gated by reset so nothing can be accepted while the block is held.
  assign cmd_ready = reset && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign accept    = cmd_valid && cmd_ready;
  assign start     = accept && is_start(cmd_op);
  assign stop      = accept && !is_start(cmd_op);
  assign match     = (count == target_q);

`ifdef COUNT_SEQ_PRESCALE_EN
  count_seq_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == S_CLEAR),
    .run   (state_q == S_RUN),
    .tick  (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    period_d = period_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = cmd_target;
          mode_d   = op_e'(cmd_op);
          period_d = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        // A command wins over a match landing in the same cycle.
        if (start) begin
          target_d = cmd_target;
          mode_d   = op_e'(cmd_op);
          period_d = '0;
          state_d  = S_CLEAR;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        period_d = period_q + 1'b1;
        state_d  = (mode_q == OP_PERIODIC) ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= OP_ONESHOT;
      target_q <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      period_q <= period_d;
    end
  end

  assign cnt_clr    = (state_q == S_CLEAR);
  assign cnt_en     = (state_q == S_RUN) && !match && tick;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign period_cnt = period_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a behavioural counter model.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int W   = 8;
  localparam int PRE = 4;
`ifdef COUNT_SEQ_PRESCALE_EN
  localparam int PS = PRE;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_target = '0;
  logic [W-1:0] count = '0;
  logic         cnt_clr, cnt_en, done, busy;
  logic [W-1:0] period_cnt;

  count_sequencer #(.WIDTH(W), .PRESCALE(PRE)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_target (cmd_target),
    .count      (count),
    .cnt_clr    (cnt_clr),
    .cnt_en     (cnt_en),
    .done       (done),
    .busy       (busy),
    .period_cnt (period_cnt)
  );

  always #5 clk = ~clk;

  // Counter datapath model.
  always @(posedge clk) begin
    if (cnt_clr)     count <= '0;
    else if (cnt_en) count <= count + 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int tg; } exp_t;
  exp_t q[$];

  typedef struct { logic [1:0] op; int tgt; } vec_t;
  vec_t vecs[7];

  int n_pass = 0, n_tot = 0;
  int en_cnt = 0, done_seen = 0;
  int t_acc = 0;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard: each done pulse pops the expected cycle and target.
  always @(negedge clk) begin
    if (reset) begin
      if (cnt_clr)     en_cnt = 0;
      else if (cnt_en) en_cnt++;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("done_count", int'(count), e.tg);
          chk("en_cycles", en_cnt, e.tg);
        end
        done_seen++;
      end
    end
  end

  task automatic send(logic [1:0] op, int tgt, bit push);
    int b = 0;
    while (!cmd_ready && b < 100) begin @(negedge clk); b++; end
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_target = tgt[W-1:0];
    t_acc      = cyc;
    if (push && is_start(op)) q.push_back('{at: t_acc + 3 + tgt * PS, tg: tgt});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n0 = done_seen;
    int b = 0;
    while (done_seen == n0 && b < budget) begin @(negedge clk); #1; b++; end
    if (done_seen == n0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idle(int budget);
    int b = 0;
    while (busy && b < budget) begin @(negedge clk); b++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_count(int v, int budget);
    int b = 0;
    while (int'(count) != v && b < budget) begin @(negedge clk); b++; end
    if (int'(count) != v) chk("count_timeout", int'(count), v);
  endtask

  initial begin
    vecs[0] = '{OP_ONESHOT, 5};
    vecs[1] = '{OP_ONESHOT, 0};
    vecs[2] = '{OP_ONESHOT, 1};
    vecs[3] = '{OP_ONESHOT, 2};
    vecs[4] = '{OP_STOP,    0};
    vecs[5] = '{OP_RSVD,    9};
    vecs[6] = '{OP_ONESHOT, 255};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_period", period_cnt, 0);

    foreach (vecs[i]) begin
      logic st;
      st = is_start(vecs[i].op);
      send(vecs[i].op, vecs[i].tgt, 1'b1);
      chk("tbl_clr", cnt_clr, st);
      chk("tbl_busy", busy, st);
      wait_idle(260 * PS + 20);
      chk("tbl_idle_cycle", cyc, st ? t_acc + 4 + vecs[i].tgt * PS : t_acc + 1);
    end
    chk("tbl_queue_empty", q.size(), 0);

    // Periodic: three periods then STOP.
    send(OP_PERIODIC, 3, 1'b1);
    for (int k = 1; k <= 2; k++) q.push_back('{at: t_acc + 3 + 3 * PS + k * (3 * PS + 3), tg: 3});
    for (int k = 1; k <= 3; k++) begin
      wait_done(50 * PS);
      @(negedge clk);
      chk("period_cnt", period_cnt, k);
    end
    send(OP_STOP, 0, 1'b0);
    chk("stop_busy", busy, 0);
    chk("stop_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("stop_queue", q.size(), 0);
    chk("stop_period_hold", period_cnt, 3);

    // Restart mid-run with a new one-shot target.
    send(OP_PERIODIC, 4, 1'b1);
    wait_done(50 * PS);
    @(negedge clk);
    chk("restart_period1", period_cnt, 1);
    wait_count(2, 50 * PS);
    send(OP_ONESHOT, 7, 1'b1);
    chk("restart_clr", cnt_clr, 1);
    chk("restart_period0", period_cnt, 0);
    wait_idle(50 * PS);
    chk("restart_queue", q.size(), 0);

    // Asynchronous reset while running.
    send(OP_ONESHOT, 9, 1'b0);
    wait_count(4, 50 * PS);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt_en", cnt_en, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt_clr", cnt_clr, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_idle", busy, 0);
    chk("arst_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
